// File: rtl/sdram_arbiter.sv
// Command-bus arbiter for the SDRAM init/refresh/write/read sequencers.
// Refresh wins over write/read, write and read alternate, and a watchdog aborts stuck grants.
module sdram_arbiter #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        arb_clk,
  input  logic        arb_rst_n,
  input  logic        init_end,
  input  logic [3:0]  init_cmd,
  input  logic [1:0]  init_bank,
  input  logic [12:0] init_addr,
  input  logic        aref_req,
  input  logic        aref_end,
  input  logic [3:0]  aref_cmd,
  input  logic [1:0]  aref_bank,
  input  logic [12:0] aref_addr,
  input  logic        wr_req,
  input  logic        wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [1:0]  wr_bank,
  input  logic [12:0] wr_addr,
  input  logic        wr_sdram_en,
  input  logic [15:0] wr_sdram_data,
  input  logic        rd_req,
  input  logic        rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [1:0]  rd_bank,
  input  logic [12:0] rd_addr,
  output logic        aref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic [3:0]  sdram_cmd,
  output logic [1:0]  sdram_bank,
  output logic [12:0] sdram_addr,
  output logic [15:0] sdram_dq_out,
  output logic        sdram_dq_oe,
  output logic        arb_err
);

  localparam int unsigned CW = 10;
  localparam logic [3:0]  CMD_NOP  = 4'b0111;
  localparam logic [1:0]  BANK_NOP = 2'b11;
  localparam logic [12:0] ADDR_NOP = 13'h1fff;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_AREF,
    S_WRITE,
    S_READ
  } state_t;

  state_t        state, state_nxt;
  state_t        last_grant, last_grant_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          err_nxt;
  logic          timeout;

  // Grant has been held for TIMEOUT cycles once this cycle completes
  assign timeout = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge arb_clk or negedge arb_rst_n) begin
    if (!arb_rst_n) begin
      state      <= S_INIT;
      last_grant <= S_READ;
      cnt        <= '0;
      arb_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      cnt        <= cnt_nxt;
      arb_err    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    cnt_nxt        = '0;
    err_nxt        = 1'b0;
    sdram_cmd      = CMD_NOP;
    sdram_bank     = BANK_NOP;
    sdram_addr     = ADDR_NOP;
    sdram_dq_oe    = 1'b0;

    case (state)
      S_INIT: begin
        sdram_cmd  = init_cmd;
        sdram_bank = init_bank;
        sdram_addr = init_addr;
        if (init_end) state_nxt = S_IDLE;
      end

      S_IDLE: begin
        // Contended write/read goes to whichever did not have the last grant
        if (aref_req) begin
          state_nxt = S_AREF;
        end else if (wr_req && (!rd_req || last_grant != S_WRITE)) begin
          state_nxt      = S_WRITE;
          last_grant_nxt = S_WRITE;
        end else if (rd_req) begin
          state_nxt      = S_READ;
          last_grant_nxt = S_READ;
        end
      end

      S_AREF: begin
        sdram_cmd  = aref_cmd;
        sdram_bank = aref_bank;
        sdram_addr = aref_addr;
        cnt_nxt    = cnt + CW'(1);
        if (aref_end) begin
          state_nxt = S_IDLE;
        end else if (timeout) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
          cnt_nxt   = '0;
        end
      end

      S_WRITE: begin
        sdram_cmd   = wr_cmd;
        sdram_bank  = wr_bank;
        sdram_addr  = wr_addr;
        sdram_dq_oe = wr_sdram_en;
        cnt_nxt     = cnt + CW'(1);
        if (wr_end) begin
          state_nxt = S_IDLE;
        end else if (timeout) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
          cnt_nxt   = '0;
        end
      end

      S_READ: begin
        sdram_cmd  = rd_cmd;
        sdram_bank = rd_bank;
        sdram_addr = rd_addr;
        cnt_nxt    = cnt + CW'(1);
        if (rd_end) begin
          state_nxt = S_IDLE;
        end else if (timeout) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
          cnt_nxt   = '0;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  assign aref_en      = (state == S_AREF);
  assign wr_en        = (state == S_WRITE);
  assign rd_en        = (state == S_READ);
  assign sdram_dq_out = wr_sdram_data;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: grant order scoreboard plus timing, DQ, watchdog and reset checks.
module tb_sdram_arbiter;

  logic        arb_clk = 1'b0;
  logic        arb_rst_n = 1'b0;
  logic        init_end = 1'b0;
  logic [3:0]  init_cmd = 4'h1;
  logic [1:0]  init_bank = 2'd0;
  logic [12:0] init_addr = 13'h0001;
  logic        aref_req = 1'b0, aref_end = 1'b0;
  logic [3:0]  aref_cmd = 4'h2;
  logic [1:0]  aref_bank = 2'd1;
  logic [12:0] aref_addr = 13'h0aaa;
  logic        wr_req = 1'b0, wr_end = 1'b0;
  logic [3:0]  wr_cmd = 4'h4;
  logic [1:0]  wr_bank = 2'd2;
  logic [12:0] wr_addr = 13'h0555;
  logic        wr_sdram_en = 1'b0;
  logic [15:0] wr_sdram_data = 16'h0000;
  logic        rd_req = 1'b0, rd_end = 1'b0;
  logic [3:0]  rd_cmd = 4'h5;
  logic [1:0]  rd_bank = 2'd3;
  logic [12:0] rd_addr = 13'h1234;
  logic        aref_en, wr_en, rd_en;
  logic [3:0]  sdram_cmd;
  logic [1:0]  sdram_bank;
  logic [12:0] sdram_addr;
  logic [15:0] sdram_dq_out;
  logic        sdram_dq_oe;
  logic        arb_err;

  localparam int G_AREF = 1;
  localparam int G_WR   = 2;
  localparam int G_RD   = 3;

  int total = 0;
  int bad = 0;
  int exp_q[$];
  logic [2:0] prev_g = 3'b000;

  sdram_arbiter dut (
    .arb_clk(arb_clk), .arb_rst_n(arb_rst_n), .init_end(init_end),
    .init_cmd(init_cmd), .init_bank(init_bank), .init_addr(init_addr),
    .aref_req(aref_req), .aref_end(aref_end),
    .aref_cmd(aref_cmd), .aref_bank(aref_bank), .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_end(wr_end),
    .wr_cmd(wr_cmd), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
    .rd_req(rd_req), .rd_end(rd_end),
    .rd_cmd(rd_cmd), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdram_cmd(sdram_cmd), .sdram_bank(sdram_bank), .sdram_addr(sdram_addr),
    .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe), .arb_err(arb_err)
  );

  always #5 arb_clk = ~arb_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge arb_clk);
    #1;
  endtask

  // Scoreboard side: every new grant is popped against the expected order
  always @(negedge arb_clk) begin
    logic [2:0] cur;
    int code;
    cur = {aref_en, wr_en, rd_en};
    check("onehot", 32'($countones(cur) <= 1), 32'd1);
    if (cur != 3'b000 && prev_g == 3'b000) begin
      code = aref_en ? G_AREF : (wr_en ? G_WR : G_RD);
      if (exp_q.size() == 0) check("sb_extra", 32'(code), 32'd0);
      else check("sb_order", 32'(code), 32'(exp_q.pop_front()));
    end
    prev_g = cur;
  end

  // Wait for a grant, hold it, then pulse the matching end; optionally drop its request
  task automatic serve(input int len, input bit drop);
    int n = 0;
    while (!(aref_en || wr_en || rd_en) && n < 20) begin
      tick();
      n++;
    end
    check("grant_wait", 32'(n < 20), 32'd1);
    check("grant_cmd", 32'(sdram_cmd),
          aref_en ? 32'(aref_cmd) : (wr_en ? 32'(wr_cmd) : 32'(rd_cmd)));
    repeat (len) tick();
    if (aref_en) begin
      aref_end = 1'b1;
      if (drop) aref_req = 1'b0;
    end else if (wr_en) begin
      wr_end = 1'b1;
      if (drop) wr_req = 1'b0;
    end else if (rd_en) begin
      rd_end = 1'b1;
      if (drop) rd_req = 1'b0;
    end
    tick();
    aref_end = 1'b0;
    wr_end = 1'b0;
    rd_end = 1'b0;
    check("idle_gap", 32'({aref_en, wr_en, rd_en}), 32'd0);
    check("idle_cmd", 32'(sdram_cmd), 32'h7);
  endtask

  initial begin
    int n;
    // Reset state and INIT hold with a pending write
    wr_req = 1'b1;
    #2;
    check("rst_cmd", 32'(sdram_cmd), 32'(init_cmd));
    check("rst_grants", 32'({aref_en, wr_en, rd_en}), 32'd0);
    check("rst_err", 32'(arb_err), 32'd0);
    #10 arb_rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("init_wr_en", 32'(wr_en), 32'd0);
      check("init_cmd", 32'(sdram_cmd), 32'(init_cmd));
    end
    exp_q.push_back(G_WR);
    init_end = 1'b1;
    tick();
    check("idle_after_init", 32'(sdram_cmd), 32'h7);
    check("idle_bank", 32'(sdram_bank), 32'h3);
    check("idle_addr", 32'(sdram_addr), 32'h1fff);
    check("wr_not_yet", 32'(wr_en), 32'd0);
    tick();
    check("wr_granted", 32'(wr_en), 32'd1);
    serve(0, 1'b1);

    // Lone read so the next contended pick is a write
    rd_req = 1'b1;
    exp_q.push_back(G_RD);
    serve(1, 1'b1);

    // All three at once, then continuous write/read alternation
    aref_req = 1'b1;
    wr_req = 1'b1;
    rd_req = 1'b1;
    exp_q.push_back(G_AREF);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(G_WR);
      exp_q.push_back(G_RD);
    end
    serve(1, 1'b1);
    for (int i = 0; i < 8; i++) serve(2, i >= 6);

    // Refresh arriving mid-write waits; DQ driven only while writing
    wr_sdram_data = 16'hA5A5;
    wr_sdram_en = 1'b1;
    wr_req = 1'b1;
    exp_q.push_back(G_WR);
    exp_q.push_back(G_AREF);
    tick();
    check("t4_wr_en", 32'(wr_en), 32'd1);
    aref_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_hold_wr", 32'(wr_en), 32'd1);
      check("t4_no_aref", 32'(aref_en), 32'd0);
      check("t4_oe", 32'(sdram_dq_oe), 32'd1);
      check("t4_dq", 32'(sdram_dq_out), 32'hA5A5);
    end
    wr_end = 1'b1;
    wr_req = 1'b0;
    tick();
    wr_end = 1'b0;
    check("t4_gap_aref", 32'(aref_en), 32'd0);
    check("t4_gap_oe", 32'(sdram_dq_oe), 32'd0);
    check("t4_gap_dq", 32'(sdram_dq_out), 32'hA5A5);
    tick();
    check("t4_aref_en", 32'(aref_en), 32'd1);
    check("t4_aref_oe", 32'(sdram_dq_oe), 32'd0);
    serve(1, 1'b1);
    wr_sdram_en = 1'b0;

    // Watchdog: a read that never ends is dropped after TIMEOUT cycles
    rd_req = 1'b1;
    exp_q.push_back(G_RD);
    tick();
    check("t5_rd_en", 32'(rd_en), 32'd1);
    check("t5_err_low", 32'(arb_err), 32'd0);
    rd_req = 1'b0;
    n = 0;
    while (rd_en && n < 1100) begin
      tick();
      n++;
    end
    check("t5_len", 32'(n), 32'd1023);
    check("t5_err", 32'(arb_err), 32'd1);
    check("t5_cmd", 32'(sdram_cmd), 32'h7);
    check("t5_bank", 32'(sdram_bank), 32'h3);
    check("t5_addr", 32'(sdram_addr), 32'h1fff);
    tick();
    check("t5_err_pulse", 32'(arb_err), 32'd0);

    // End pulse on the timeout cycle is a normal end
    rd_req = 1'b1;
    exp_q.push_back(G_RD);
    tick();
    rd_req = 1'b0;
    repeat (1022) tick();
    check("t5b_still_rd", 32'(rd_en), 32'd1);
    rd_end = 1'b1;
    tick();
    rd_end = 1'b0;
    check("t5b_rd_off", 32'(rd_en), 32'd0);
    check("t5b_no_err", 32'(arb_err), 32'd0);
    tick();
    check("t5b_no_err2", 32'(arb_err), 32'd0);

    // Asynchronous reset in the middle of a write
    wr_req = 1'b1;
    wr_sdram_en = 1'b1;
    exp_q.push_back(G_WR);
    tick();
    tick();
    check("t6_wr_en", 32'(wr_en), 32'd1);
    #2 arb_rst_n = 1'b0;
    wr_req = 1'b0;
    #1;
    check("t6_wr_drop", 32'(wr_en), 32'd0);
    check("t6_oe_drop", 32'(sdram_dq_oe), 32'd0);
    check("t6_cmd_init", 32'(sdram_cmd), 32'(init_cmd));
    check("t6_addr_init", 32'(sdram_addr), 32'(init_addr));
    #4 arb_rst_n = 1'b1;
    #1;
    check("t6_still_init", 32'(sdram_cmd), 32'(init_cmd));
    tick();
    check("t6_idle", 32'(sdram_cmd), 32'h7);
    check("t6_no_grant", 32'({aref_en, wr_en, rd_en}), 32'd0);
    wr_sdram_en = 1'b0;

    repeat (3) tick();
    check("sb_left", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Sits between the SDRAM init, auto-refresh, write and read sequencers and the physical SDRAM command/address/data pins.
- Grants the single SDRAM command bus to exactly one sequencer at a time and muxes that sequencer's cmd/bank/addr/data onto the pins.
- Priority: auto-refresh > write/read. Writes and reads alternate round-robin when both are pending.
- Runs a watchdog that aborts a grant whose sequencer never signals end.

Parameters:
- TIMEOUT, 1023: maximum cycles a grant may stay in AREF/WRITE/READ before forced release (10-bit counter).

Ports:
- arb_clk  in  1  system clock
- arb_rst_n  in  1  asynchronous active-low reset
- init_end  in  1  power-up init complete (level, stays high)
- init_cmd  in  4  init command {cs_n,ras_n,cas_n,we_n}
- init_bank  in  2  init bank
- init_addr  in  13  init address
- aref_req  in  1  refresh request (level, held until serviced)
- aref_end  in  1  refresh sequence done (1-cycle pulse)
- aref_cmd/aref_bank/aref_addr  in  4/2/13  refresh pin values
- wr_req  in  1  write request (level)
- wr_end  in  1  write done pulse
- wr_cmd/wr_bank/wr_addr  in  4/2/13  write pin values
- wr_sdram_en  in  1  write module driving DQ
- wr_sdram_data  in  16  write data
- rd_req  in  1  read request (level)
- rd_end  in  1  read done pulse
- rd_cmd/rd_bank/rd_addr  in  4/2/13  read pin values
- aref_en  out  1  grant to refresh sequencer
- wr_en  out  1  grant to write sequencer
- rd_en  out  1  grant to read sequencer
- sdram_cmd  out  4  {cs_n,ras_n,cas_n,we_n} to pins
- sdram_bank  out  2  bank to pins
- sdram_addr  out  13  address to pins
- sdram_dq_out  out  16  DQ output value
- sdram_dq_oe  out  1  DQ output enable
- arb_err  out  1  watchdog abort pulse

Behaviour:
- Reset is asynchronous and active-low, on arb_rst_n. Reset values:
  - state = INIT
  - last_grant = READ
  - watchdog counter = 0
  - arb_err = 0
- States: INIT, IDLE, AREF, WRITE, READ. State register clocked on arb_clk; next-state logic is combinational.
- INIT:
  - pins = init_cmd/init_bank/init_addr.
  - -> IDLE when init_end = 1; all requests ignored until then.
- IDLE:
  - pins = NOP 4'b0111, bank 2'b11, addr 13'h1fff.
  - aref_req -> AREF.
  - else if wr_req && rd_req: grant the one not equal to last_grant.
  - else wr_req -> WRITE; else rd_req -> READ; else stay IDLE.
- AREF: pins = aref_*; -> IDLE on aref_end.
- WRITE: pins = wr_*; -> IDLE on wr_end; last_grant <= WRITE on entry.
- READ: pins = rd_*; -> IDLE on rd_end; last_grant <= READ on entry.
- Grant outputs are combinational decodes of the state register: aref_en = (state==AREF), wr_en = (state==WRITE), rd_en = (state==READ).
  - Grant rises one cycle after the request is sampled in IDLE.
  - At most one grant is high at any time.
- No pre-emption: an aref_req arriving during WRITE/READ waits until wr_end/rd_end, then IDLE for 1 cycle, then AREF.
- Minimum one IDLE cycle between consecutive grants.
- End pulses from sequencers that are not granted are ignored.
- DQ:
  - sdram_dq_out = wr_sdram_data always.
  - sdram_dq_oe = wr_sdram_en && state==WRITE; 0 in every other state.
- Watchdog:
  - Counter cleared in INIT/IDLE; increments each cycle in AREF/WRITE/READ.
  - If the counter reaches TIMEOUT without the matching end pulse: next state = IDLE, arb_err high for exactly 1 cycle (registered), counter cleared.
  - last_grant is kept as set on entry.
- Simultaneous end pulse and timeout in the same cycle: treat as a normal end, arb_err stays 0.
- Reset mid-grant: immediate return to INIT, grants drop asynchronously, pins go to the init_* values.

Test Plan:
1. Reset, init_end = 0 for 20 cycles with wr_req = 1 -> state stays INIT, wr_en = 0, sdram_cmd = init_cmd. Raise init_end -> IDLE next cycle, wr_en = 1 the cycle after.
2. In IDLE, assert aref_req, wr_req and rd_req in the same cycle -> aref_en first. After aref_end: 1 IDLE cycle, then wr_en. After wr_end: 1 IDLE cycle, then rd_en (round-robin).
3. Hold wr_req and rd_req continuously for 6 grants -> grant order W,R,W,R,W,R. Never two grants high at once.
4. During WRITE (wr_sdram_en = 1, data 16'hA5A5), assert aref_req -> sdram_dq_oe = 1, dq_out = A5A5 until wr_end. aref_en follows 2 cycles after wr_end.
5. Grant READ and never pulse rd_end -> at cycle TIMEOUT = 1023: rd_en = 0, arb_err = 1 for one cycle, state IDLE, pins NOP/2'b11/13'h1fff.
6. Drop arb_rst_n mid-WRITE -> wr_en = 0 and sdram_dq_oe = 0 immediately. Release with init_end = 1 -> INIT 1 cycle, then IDLE.
